// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and helpers for the LFSR step controller: command opcodes, FSM states,
// and the rate clamp used by SET_DIV.
package lfsr_ctrl_pkg;

  localparam int unsigned DIV_POW_W = 5;
  localparam int unsigned OP_W      = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 3'd0,
    OP_STOP    = 3'd1,
    OP_RUN     = 3'd2,
    OP_STEP    = 3'd3,
    OP_BURST   = 3'd4,
    OP_SET_DIV = 3'd5,
    OP_LOAD    = 3'd6,
    OP_RSVD    = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BURST = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  // Limit a requested rate exponent to what the prescaler can represent.
  function automatic logic [DIV_POW_W-1:0] clamp_pow(input logic [DIV_POW_W-1:0] p,
                                                    input int unsigned cnt_w);
    if (32'(p) > cnt_w - 32'd1) return DIV_POW_W'(cnt_w - 32'd1);
    return p;
  endfunction

endpackage

// File: rtl/lfsr_tick_gen.sv
// Free-running prescaler that flags one cycle out of every 2^div_pow while enabled.
module lfsr_tick_gen
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_POW_W-1:0] div_pow,
  output logic                 tick
);

  logic [CNT_W-1:0] prescaler;
  logic [CNT_W-1:0] mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (clr) begin
      prescaler <= '0;
    end else if (en) begin
      prescaler <= prescaler + CNT_W'(1);
    end
  end

  // Low div_pow bits all ones; an empty mask (div_pow = 0) ticks every cycle.
  always_comb begin
    mask = ~({CNT_W{1'b1}} << div_pow);
    tick = en && ((prescaler & mask) == mask);
  end

endmodule

// File: rtl/lfsr_step_controller.sv
// Command-driven sequencer for the LFSR core: turns run/step/burst/load requests into
// single-cycle step_en and seed_load pulses at a programmable 2^P rate.
module lfsr_step_controller
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned DIV_POW_DEFAULT = 26,
  parameter int unsigned BURST_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [BURST_W-1:0]   cmd_arg,
  input  logic                 abort,
  output logic                 step_en,
  output logic                 seed_load,
  output logic                 busy,
  output logic                 done,
  output logic [BURST_W-1:0]   remaining,
  output logic [DIV_POW_W-1:0] div_pow
);

  state_e               state;
  state_e               state_next;
  logic                 step_en_next;
  logic                 seed_load_next;
  logic                 done_next;
  logic [BURST_W-1:0]   remaining_next;
  logic [DIV_POW_W-1:0] div_pow_next;
  logic                 clr_c;
  logic                 accept_c;
  logic                 tick;
  cmd_op_e              op_c;

  lfsr_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr_c),
    .en     ((state == ST_RUN) || (state == ST_BURST)),
    .div_pow(div_pow),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      step_en   <= 1'b0;
      seed_load <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      remaining <= '0;
      div_pow   <= DIV_POW_W'(DIV_POW_DEFAULT);
    end else begin
      state     <= state_next;
      step_en   <= step_en_next;
      seed_load <= seed_load_next;
      done      <= done_next;
      busy      <= (state_next != ST_IDLE);
      cmd_ready <= (state_next == ST_IDLE) || (state_next == ST_RUN);
      remaining <= remaining_next;
      div_pow   <= div_pow_next;
    end
  end

  // Next state and next registered outputs; pulses are set on the edge that enters a state.
  always_comb begin
    state_next     = state;
    step_en_next   = 1'b0;
    seed_load_next = 1'b0;
    done_next      = 1'b0;
    remaining_next = remaining;
    div_pow_next   = div_pow;
    clr_c          = 1'b0;
    accept_c       = cmd_valid && cmd_ready;
    op_c           = cmd_op_e'(cmd_op);

    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          case (op_c)
            OP_RUN: begin
              state_next = ST_RUN;
              clr_c      = 1'b1;
            end
            OP_STEP: begin
              state_next   = ST_STEP;
              step_en_next = 1'b1;
              done_next    = 1'b1;
            end
            OP_BURST: begin
              if (cmd_arg == '0) begin
                done_next = 1'b1;
              end else begin
                state_next     = ST_BURST;
                remaining_next = cmd_arg;
                clr_c          = 1'b1;
              end
            end
            OP_LOAD: begin
              state_next     = ST_LOAD;
              seed_load_next = 1'b1;
              done_next      = 1'b1;
            end
            OP_SET_DIV: begin
              div_pow_next = clamp_pow(cmd_arg[DIV_POW_W-1:0], CNT_W);
              clr_c        = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        step_en_next = tick;
        if (accept_c) begin
          case (op_c)
            OP_STOP: state_next = ST_IDLE;
            OP_SET_DIV: begin
              div_pow_next = clamp_pow(cmd_arg[DIV_POW_W-1:0], CNT_W);
              clr_c        = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_BURST: begin
        if (tick) begin
          step_en_next   = 1'b1;
          remaining_next = remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_STEP, ST_LOAD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Abort wins over everything, including a command accepted on the same edge.
    if (abort) begin
      state_next     = ST_IDLE;
      step_en_next   = 1'b0;
      seed_load_next = 1'b0;
      done_next      = 1'b0;
      remaining_next = '0;
      div_pow_next   = div_pow;
      clr_c          = 1'b0;
    end
  end

endmodule
